bf_mem_responder: RTL and testbench

//  Memory-side responder for the BF core: accepts one program/data access per request
//  (valid/ready) and executes it off-chip over an 8-bit shared bus with a 4-phase
//  stb/ack handshake. Sits between the core datapath (addr mux, write, temp data) and the
//  TT bidirectional pins; the external host owns program and tape memory.

---
 rtl/bf_mem_responder_if.sv | 30 +++
 rtl/bf_mem_responder.sv | 146 ++++++++++++++
 tb/tb_bf_mem_responder.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bf_mem_responder_if.sv
// rtl/bf_mem_responder_if.sv - core request/response and host bus signals of bf_mem_responder
// The slave modport is the responder's view; master is the core plus host side.
interface bf_mem_responder_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_space;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_wdata;
  logic              rsp_valid;
  logic [7:0]        rsp_rdata;
  logic              rsp_err;
  logic [7:0]        bus_out;
  logic              bus_oe;
  logic [7:0]        bus_in;
  logic              bus_stb;
  logic              bus_ack;

  modport slave (
    input  req_valid, req_write, req_space, req_addr, req_wdata, bus_in, bus_ack,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, bus_out, bus_oe, bus_stb
  );

  modport master (
    output req_valid, req_write, req_space, req_addr, req_wdata, bus_in, bus_ack,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, bus_out, bus_oe, bus_stb
  );
endinterface

// File: rtl/bf_mem_responder.sv
// rtl/bf_mem_responder.sv - executes one core memory access over an 8-bit 4-phase stb/ack host bus
// Sequence per access: CMD byte, ADDR byte, DATA byte, each a strobe-high then strobe-low substate.
module bf_mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              en,
  bf_mem_responder_if.slave io
);

  typedef enum logic [3:0] {
    IDLE, CMD_HI, CMD_LO, ADDR_HI, ADDR_LO, TURN, DATA_HI, DATA_LO, RESP
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t            state, state_n, phase_next;
  logic [7:0]        cnt, cnt_n;
  logic              write_q, write_n, space_q, space_n, err_q, err_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [7:0]        wdata_q, wdata_n, rdata_q, rdata_n;
  logic              ack_q;
  logic [7:0]        in_q;
  logic [7:0]        cmd_byte;
  logic              is_hi, is_lo, phase_done;

  assign cmd_byte   = {write_q, space_q, 6'(addr_q >> 8)};
  assign is_hi      = (state == CMD_HI) || (state == ADDR_HI) || (state == DATA_HI);
  assign is_lo      = (state == CMD_LO) || (state == ADDR_LO) || (state == DATA_LO);
  assign phase_done = (is_hi && ack_q) || (is_lo && !ack_q);

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      write_q <= 1'b0;
      space_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 8'd0;
      rdata_q <= 8'd0;
      ack_q   <= 1'b0;
      in_q    <= 8'd0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      write_q <= write_n;
      space_q <= space_n;
      err_q   <= err_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      rdata_q <= rdata_n;
      ack_q   <= io.bus_ack;
      in_q    <= io.bus_in;
    end
  end

  always_comb begin
    phase_next = IDLE;
    case (state)
      CMD_HI:  phase_next = CMD_LO;
      CMD_LO:  phase_next = ADDR_HI;
      ADDR_HI: phase_next = ADDR_LO;
      ADDR_LO: phase_next = write_q ? DATA_HI : TURN;
      DATA_HI: phase_next = DATA_LO;
      DATA_LO: phase_next = RESP;
      default: phase_next = IDLE;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    write_n = write_q;
    space_n = space_q;
    err_n   = err_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    rdata_n = rdata_q;
    if (en) begin
      case (state)
        IDLE: begin
          if (io.req_valid) begin
            write_n = io.req_write;
            space_n = io.req_space;
            addr_n  = io.req_addr;
            wdata_n = io.req_wdata;
            err_n   = 1'b0;
            rdata_n = 8'd0;
            cnt_n   = 8'd0;
            state_n = CMD_HI;
          end
        end
        TURN: begin
          cnt_n   = 8'd0;
          state_n = DATA_HI;
        end
        RESP: state_n = IDLE;
        default: begin
          if (phase_done) begin
            cnt_n   = 8'd0;
            state_n = phase_next;
            if (state == DATA_HI && !write_q) rdata_n = in_q;
          end else if (cnt == LAST_WAIT) begin
            // Host stopped answering: abandon the access and report it.
            err_n   = 1'b1;
            state_n = RESP;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      endcase
    end
  end

  always_comb begin
    io.bus_out = 8'd0;
    io.bus_oe  = 1'b0;
    io.bus_stb = is_hi;
    case (state)
      CMD_HI, CMD_LO: begin
        io.bus_out = cmd_byte;
        io.bus_oe  = 1'b1;
      end
      ADDR_HI, ADDR_LO: begin
        io.bus_out = addr_q[7:0];
        io.bus_oe  = 1'b1;
      end
      DATA_HI, DATA_LO: begin
        if (write_q) begin
          io.bus_out = wdata_q;
          io.bus_oe  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign io.req_ready = (state == IDLE);
  assign io.rsp_valid = (state == RESP) && en;
  assign io.rsp_err   = (state == RESP) && err_q;
  assign io.rsp_rdata = ((state == RESP) && !err_q) ? rdata_q : 8'd0;

endmodule

// File: tb/tb_bf_mem_responder.sv
// tb/tb_bf_mem_responder.sv - randomized and directed bench for bf_mem_responder
// The host mirrors stb onto ack after host_d cycles; a monitor checks every cycle.
module tb_bf_mem_responder;
  localparam int ADDR_W  = 12;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic nreset;
  logic en;

  bf_mem_responder_if #(.ADDR_W(ADDR_W)) io ();

  bf_mem_responder #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .nreset(nreset), .en(en), .io(io)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  int         host_d = 1;
  bit         host_mute = 1'b0;
  logic [7:0] host_rdata = 8'd0;
  bit   [7:0] hist = 8'd0;

  always @(negedge clk) begin
    hist       = {hist[6:0], io.bus_stb};
    io.bus_ack = host_mute ? 1'b0 : hist[host_d];
    io.bus_in  = host_rdata;
  end

  bit         active = 1'b0, prev_stb = 1'b0, exp_idle = 1'b0, exp_rst = 1'b0;
  bit         m_write, m_mute, exp_err;
  int         m_d, cyc, stall, rises, exp_lat, exp_rises, obs_lat, n_done = 0;
  logic [7:0] exp_bytes [3];
  logic [7:0] obs_b [3];
  bit         exp_oe_b [3];
  bit         skip_b [3];
  logic [7:0] last_byte, exp_rdata, obs_rdata;
  bit         obs_err;

  always begin
    @(negedge clk);
    #1;
    if (!nreset) begin
      exp_rst = 1'b1;
      active  = 1'b0;
    end else begin
      if (exp_rst) begin
        check("rst_state", int'({io.bus_stb, io.bus_oe, io.req_ready, io.rsp_valid, io.rsp_err}), 5'b00100);
        check("rst_data", int'({io.bus_out, io.rsp_rdata}), 0);
        exp_rst = 1'b0;
      end
      if (exp_idle) begin
        check("ready_after_resp", int'(io.req_ready), 1);
        exp_idle = 1'b0;
      end
      if (active) begin
        cyc++;
        if (!en) begin
          stall++;
          check("rsp_gated", int'(io.rsp_valid), 0);
        end
        check("busy_not_ready", int'(io.req_ready), 0);
        if (io.bus_stb && !prev_stb) begin
          if (rises < 3) begin
            obs_b[rises] = io.bus_out;
            if (!skip_b[rises]) check("rise_byte", int'(io.bus_out), int'(exp_bytes[rises]));
            check("rise_oe", int'(io.bus_oe), int'(exp_oe_b[rises]));
            last_byte = io.bus_out;
          end
          rises++;
        end
        if (!io.bus_stb && prev_stb && !io.rsp_valid)
          check("fall_byte", int'(io.bus_out), int'(last_byte));
        if (!m_write && !m_mute && stall == 0 && cyc == 4 * m_d + 9)
          check("turn_released", int'({io.bus_stb, io.bus_oe}), 0);
        if (io.rsp_valid) begin
          obs_lat   = cyc;
          obs_rdata = io.rsp_rdata;
          obs_err   = io.rsp_err;
          check("rsp_cycle", cyc, exp_lat + stall);
          check("rsp_rdata", int'(io.rsp_rdata), int'(exp_rdata));
          check("rsp_err", int'(io.rsp_err), int'(exp_err));
          check("rsp_phases", rises, exp_rises);
          check("rsp_bus_idle", int'({io.bus_stb, io.bus_oe}), 0);
          active   = 1'b0;
          exp_idle = 1'b1;
          n_done++;
        end else if (cyc > 400) begin
          check("rsp_bound", cyc, exp_lat);
          active = 1'b0;
        end
      end else begin
        check("idle_no_rsp", int'(io.rsp_valid), 0);
      end
      if (io.req_valid && io.req_ready && en && !active) begin
        m_write      = io.req_write;
        m_mute       = host_mute;
        m_d          = host_d;
        exp_bytes[0] = {io.req_write, io.req_space, 6'(io.req_addr / 256)};
        exp_bytes[1] = io.req_addr[7:0];
        exp_bytes[2] = io.req_wdata;
        skip_b[0]    = 1'b0;
        skip_b[1]    = 1'b0;
        skip_b[2]    = !io.req_write;
        exp_oe_b[0]  = 1'b1;
        exp_oe_b[1]  = 1'b1;
        exp_oe_b[2]  = io.req_write;
        exp_rises    = host_mute ? 1 : 3;
        exp_lat      = host_mute ? TIMEOUT + 1 : 6 * host_d + 13 + (io.req_write ? 0 : 1);
        exp_err      = host_mute;
        exp_rdata    = (io.req_write || host_mute) ? 8'd0 : host_rdata;
        active       = 1'b1;
        cyc          = 0;
        stall        = 0;
        rises        = 0;
      end
    end
    prev_stb = io.bus_stb;
  end

  task automatic run_txn(input bit wr, input bit sp, input logic [ADDR_W-1:0] a,
                         input logic [7:0] wd, input int extra_hold);
    io.req_write = wr;
    io.req_space = sp;
    io.req_addr  = a;
    io.req_wdata = wd;
    io.req_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < extra_hold; i++) begin
      io.req_write = 1'($urandom);
      io.req_space = 1'($urandom);
      io.req_addr  = ADDR_W'($urandom);
      io.req_wdata = 8'($urandom);
      @(negedge clk);
    end
    io.req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!io.req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("done_bound", int'(io.req_ready), 1);
    repeat (6) @(negedge clk);
  endtask

  task automatic pin_bytes(input string name, input logic [7:0] b0, input logic [7:0] b1);
    check({name, "_cmd"}, int'(obs_b[0]), int'(b0));
    check({name, "_addr"}, int'(obs_b[1]), int'(b1));
  endtask

  initial begin
    int n0;
    io.req_valid = 1'b0;
    io.req_write = 1'b0;
    io.req_space = 1'b0;
    io.req_addr  = '0;
    io.req_wdata = 8'd0;
    nreset = 1'b0;
    en     = 1'b1;
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    check("reset_ready", int'(io.req_ready), 1);
    check("reset_outputs", int'({io.rsp_valid, io.rsp_err, io.rsp_rdata, io.bus_out, io.bus_oe, io.bus_stb}), 0);
    repeat (2) @(negedge clk);

    n0 = n_done;
    run_txn(1'b1, 1'b1, 12'h02A, 8'h5C, 0);
    wait_done();
    check("wr_done", n_done - n0, 1);
    pin_bytes("wr", 8'hC0, 8'h2A);
    check("wr_data", int'(obs_b[2]), 8'h5C);
    check("wr_lat", obs_lat, 19);
    check("wr_rsp", int'({obs_err, obs_rdata}), 0);

    n0 = n_done;
    host_rdata = 8'h2B;
    run_txn(1'b0, 1'b0, 12'h007, 8'hFF, 2);
    wait_done();
    check("rd_done", n_done - n0, 1);
    pin_bytes("rd", 8'h00, 8'h07);
    check("rd_lat", obs_lat, 20);
    check("rd_rdata", int'(obs_rdata), 8'h2B);

    n0 = n_done;
    host_mute = 1'b1;
    run_txn(1'b1, 1'b0, 12'h123, 8'h11, 0);
    wait_done();
    host_mute = 1'b0;
    repeat (4) @(negedge clk);
    check("to_done", n_done - n0, 1);
    check("to_lat", obs_lat, 17);
    check("to_rsp", int'({obs_err, obs_rdata}), 9'h100);

    n0 = n_done;
    run_txn(1'b1, 1'b0, 12'h155, 8'h3C, 0);
    repeat (8) @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_hold", int'({io.bus_stb, io.bus_out}), 9'h155);
    end
    en = 1'b1;
    wait_done();
    check("stall_done", n_done - n0, 1);
    pin_bytes("stall", 8'h81, 8'h55);
    check("stall_lat", obs_lat, 24);

    n0 = n_done;
    run_txn(1'b1, 1'b1, 12'h0F0, 8'hA5, 0);
    repeat (13) @(negedge clk);
    check("rst_mid_data", int'({io.bus_stb, io.bus_oe, io.bus_out}), 10'h3A5);
    nreset = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    check("rst_abort", int'({io.bus_stb, io.bus_oe, io.req_ready, io.rsp_valid}), 4'b0010);
    repeat (20) @(negedge clk);
    check("rst_no_rsp", n_done - n0, 0);

    n0 = n_done;
    run_txn(1'b1, 1'b1, 12'hABC, 8'h5A, 1);
    wait_done();
    check("aw12_done", n_done - n0, 1);
    pin_bytes("aw12", 8'hCA, 8'hBC);
    check("aw12_lat", obs_lat, 19);

    for (int t = 0; t < 40; t++) begin
      host_d     = $urandom_range(1, 3);
      host_rdata = 8'($urandom);
      n0 = n_done;
      run_txn(1'($urandom), 1'($urandom), ADDR_W'($urandom), 8'($urandom), $urandom_range(0, 6));
      wait_done();
      check("rand_done", n_done - n0, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
